pd_switch_responder: RTL and testbench

//  Power-domain-side responder to the power-controller sequencer. Answers hw_sleep / pwr_on handshakes,

---
 rtl/pd_switch_responder.sv | 170 +++++++++++++++++
 tb/tb_pd_switch_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_switch_responder.sv
// pd_switch_responder: AON-side power-domain responder. Answers the controller's
// hw_sleep / pwr_on handshakes, steps the daisy-chained power-switch enables down
// and up one stage at a time, and (when PD_SEQ_CHECK_EN is defined) flags
// iso/ret/rstn/clk_en ordering violations on a sticky error output.
// Default build (PD_SEQ_CHECK_EN undefined): checker absent, o_seq_err tied low.
module pd_switch_responder #(
  parameter int N_SW_STAGES  = 4,
  parameter int SW_STAGE_DLY = 3,
  parameter int SETTLE_CYC   = 2
) (
  input  logic                   i_aon_clk,
  input  logic                   i_soc_pwr_on_rst,
  input  logic                   i_hw_sleep_req,
  input  logic                   i_pd_idle,
  output logic                   o_hw_sleep_ack,
  input  logic                   i_pwr_on_req,
  output logic                   o_pwr_on_ack,
  input  logic                   i_iso,
  input  logic                   i_ret,
  input  logic                   i_rstn,
  input  logic                   i_clk_en,
  output logic [N_SW_STAGES-1:0] o_sw_en,
  output logic [2:0]             o_pd_state,
  output logic                   o_seq_err
);

  localparam int CNT_MAX = (SW_STAGE_DLY > SETTLE_CYC) ? SW_STAGE_DLY : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]       CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]       STEP_LAST   = CNT_W'(SW_STAGE_DLY - 1);
  localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [N_SW_STAGES-1:0] SW_ALL      = '1;
  localparam logic [N_SW_STAGES-1:0] SW_FIRST    = N_SW_STAGES'(1);

  typedef enum logic [2:0] {
    ST_ON       = 3'd0,
    ST_SLP_WAIT = 3'd1,
    ST_SLP_ACK  = 3'd2,
    ST_SW_OFF   = 3'd3,
    ST_OFF      = 3'd4,
    ST_SW_ON    = 3'd5,
    ST_ON_ACK   = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             off_seq_done;

  // Step counter never wraps: it parks at its maximum value.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + CNT_W'(1);
  endfunction

  // Thermometer step up: bit0 is the first switch turned on.
  function automatic logic [N_SW_STAGES-1:0] sw_up(input logic [N_SW_STAGES-1:0] sw);
    return (sw << 1) | SW_FIRST;
  endfunction

  // Thermometer step down: the highest enabled switch goes off first.
  function automatic logic [N_SW_STAGES-1:0] sw_down(input logic [N_SW_STAGES-1:0] sw);
    return sw >> 1;
  endfunction

  // Controller has finished the power-down control sequence.
  assign off_seq_done = !i_clk_en && i_iso && i_ret && !i_rstn;
  assign o_pd_state   = state;

  // Handshake FSM with registered acks and switch enables; the ramps run on the step counter.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      state          <= ST_ON;
      o_sw_en        <= SW_ALL;
      o_hw_sleep_ack <= 1'b0;
      o_pwr_on_ack   <= 1'b0;
      cnt            <= '0;
    end else begin
      case (state)
        ST_ON: begin
          if (i_hw_sleep_req) state <= ST_SLP_WAIT;
        end
        ST_SLP_WAIT: begin
          if (!i_hw_sleep_req) begin
            state <= ST_ON;
          end else if (i_pd_idle) begin
            state          <= ST_SLP_ACK;
            o_hw_sleep_ack <= 1'b1;
          end
        end
        ST_SLP_ACK: begin
          if (!i_hw_sleep_req) begin
            state          <= ST_ON;
            o_hw_sleep_ack <= 1'b0;
          end else if (off_seq_done) begin
            state <= ST_SW_OFF;
            cnt   <= '0;
          end
        end
        ST_SW_OFF: begin
          // Once started the down-ramp always completes, even if power-on is requested.
          if (cnt == STEP_LAST) begin
            o_sw_en <= sw_down(o_sw_en);
            cnt     <= '0;
            if (o_sw_en == SW_FIRST) state <= ST_OFF;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        ST_OFF: begin
          if (i_pwr_on_req) begin
            state          <= ST_SW_ON;
            o_hw_sleep_ack <= 1'b0;
            cnt            <= '0;
          end else begin
            o_hw_sleep_ack <= i_hw_sleep_req;
          end
        end
        ST_SW_ON: begin
          if (o_sw_en != SW_ALL) begin
            if (cnt == STEP_LAST) begin
              o_sw_en <= sw_up(o_sw_en);
              cnt     <= '0;
              if ((sw_up(o_sw_en) == SW_ALL) && (SETTLE_CYC == 0)) begin
                state        <= ST_ON_ACK;
                o_pwr_on_ack <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc(cnt);
            end
          end else if (cnt == SETTLE_LAST) begin
            // All stages on and the rail has had its settle time.
            state        <= ST_ON_ACK;
            o_pwr_on_ack <= 1'b1;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        ST_ON_ACK: begin
          if (!i_pwr_on_req) begin
            state        <= ST_ON;
            o_pwr_on_ack <= 1'b0;
          end
        end
        default: state <= ST_ON;
      endcase
    end
  end

`ifdef PD_SEQ_CHECK_EN
  logic rail_down;
  logic bad_down;
  logic bad_up;

  assign rail_down = (state == ST_SW_OFF) || (state == ST_OFF) || (state == ST_SW_ON);
  assign bad_down  = rail_down && (i_clk_en || !i_iso || i_rstn);
  assign bad_up    = (state == ST_ON) && (i_iso || !i_rstn) && (o_sw_en != SW_ALL);

  // Sticky ordering-violation flag, cleared only by reset.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      o_seq_err <= 1'b0;
    end else if (bad_down || bad_up) begin
      o_seq_err <= 1'b1;
    end
  end
`else
  assign o_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_pd_switch_responder.sv
// Directed bench for pd_switch_responder: an elapsed-time behavioural model is
// compared against the DUT every cycle, plus literal expectations at key cycles.
module tb_pd_switch_responder;

  localparam int N      = 4;
  localparam int DLY    = 3;
  localparam int SETTLE = 2;
`ifdef PD_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         sleep_req = 1'b0;
  logic         pd_idle   = 1'b0;
  logic         pwr_req   = 1'b0;
  logic         iso       = 1'b0;
  logic         ret       = 1'b0;
  logic         rstn      = 1'b1;
  logic         clk_en    = 1'b1;
  logic         sleep_ack;
  logic         pwr_ack;
  logic [N-1:0] sw_en;
  logic [2:0]   pd_state;
  logic         seq_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pd_switch_responder #(
    .N_SW_STAGES (N),
    .SW_STAGE_DLY(DLY),
    .SETTLE_CYC  (SETTLE)
  ) dut (
    .i_aon_clk       (clk),
    .i_soc_pwr_on_rst(rst),
    .i_hw_sleep_req  (sleep_req),
    .i_pd_idle       (pd_idle),
    .o_hw_sleep_ack  (sleep_ack),
    .i_pwr_on_req    (pwr_req),
    .o_pwr_on_ack    (pwr_ack),
    .i_iso           (iso),
    .i_ret           (ret),
    .i_rstn          (rstn),
    .i_clk_en        (clk_en),
    .o_sw_en         (sw_en),
    .o_pd_state      (pd_state),
    .o_seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Switch pattern d cycles into the down-ramp: stage i goes off after (N-i)*DLY cycles.
  function automatic logic [N-1:0] down_pat(input int d);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i] = (d < (N - i) * DLY);
    return p;
  endfunction

  // Switch pattern d cycles into the up-ramp: stage i comes on after (i+1)*DLY cycles.
  function automatic logic [N-1:0] up_pat(input int d);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i] = (d >= (i + 1) * DLY);
    return p;
  endfunction

  // Behavioural model: ramps are derived from cycles elapsed since entering the ramp.
  int           cyc = 0;
  int           e0  = 0;
  logic [2:0]   m_state;
  logic [N-1:0] m_sw;
  logic         m_sack, m_pack, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 3'd0;
      m_sw    <= '1;
      m_sack  <= 1'b0;
      m_pack  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      if (CHK && (((m_state == 3'd3 || m_state == 3'd4 || m_state == 3'd5) &&
                   (clk_en || !iso || rstn)) ||
                  (m_state == 3'd0 && (iso || !rstn) && m_sw != '1)))
        m_err <= 1'b1;
      case (m_state)
        3'd0: if (sleep_req) m_state <= 3'd1;
        3'd1: begin
          if (!sleep_req) m_state <= 3'd0;
          else if (pd_idle) begin m_state <= 3'd2; m_sack <= 1'b1; end
        end
        3'd2: begin
          if (!sleep_req) begin m_state <= 3'd0; m_sack <= 1'b0; end
          else if (!clk_en && iso && ret && !rstn) begin m_state <= 3'd3; e0 <= cyc; end
        end
        3'd3: begin
          m_sw <= down_pat(cyc - e0);
          if (cyc - e0 >= N * DLY) m_state <= 3'd4;
        end
        3'd4: begin
          if (pwr_req) begin m_state <= 3'd5; m_sack <= 1'b0; e0 <= cyc; end
          else m_sack <= sleep_req;
        end
        3'd5: begin
          m_sw <= up_pat(cyc - e0);
          if (cyc - e0 >= N * DLY + SETTLE) begin m_state <= 3'd6; m_pack <= 1'b1; end
        end
        3'd6: if (!pwr_req) begin m_state <= 3'd0; m_pack <= 1'b0; end
        default: m_state <= 3'd0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_state",    8'(pd_state),  8'(m_state));
      check("m_sw_en",    8'(sw_en),     8'(m_sw));
      check("m_sleep_ack", 8'(sleep_ack), 8'(m_sack));
      check("m_pwr_ack",  8'(pwr_ack),   8'(m_pack));
      check("m_seq_err",  8'(seq_err),   8'(m_err));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ctrl_off();
    clk_en = 1'b0; iso = 1'b1; ret = 1'b1; rstn = 1'b0;
  endtask

  task automatic ctrl_on();
    clk_en = 1'b1; iso = 1'b0; ret = 1'b0; rstn = 1'b1;
  endtask

  initial begin
    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_state", 8'(pd_state), 8'h00);
    check("rst_sw_en", 8'(sw_en), 8'h0f);
    check("rst_sleep_ack", 8'(sleep_ack), 8'h00);
    check("rst_pwr_ack", 8'(pwr_ack), 8'h00);
    check("rst_seq_err", 8'(seq_err), 8'h00);
    wait_cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    wait_cyc(2);

    // Sleep handshake aborted in SLP_ACK
    sleep_req = 1'b1; pd_idle = 1'b1;
    wait_cyc(2);
    check("abort_ack_up", 8'(sleep_ack), 8'h01);
    check("abort_state2", 8'(pd_state), 8'h02);
    sleep_req = 1'b0;
    wait_cyc(1);
    check("abort_state", 8'(pd_state), 8'h00);
    check("abort_ack", 8'(sleep_ack), 8'h00);
    check("abort_sw_en", 8'(sw_en), 8'h0f);
    wait_cyc(2);

    // Full power-down ramp
    sleep_req = 1'b1;
    wait_cyc(2);
    check("dn_ack_cyc2", 8'(sleep_ack), 8'h01);
    wait_cyc(2);
    ctrl_off();
    wait_cyc(4);
    check("dn_sw_c8", 8'(sw_en), 8'h07);
    wait_cyc(3);
    check("dn_sw_c11", 8'(sw_en), 8'h03);
    wait_cyc(3);
    check("dn_sw_c14", 8'(sw_en), 8'h01);
    check("dn_state_c14", 8'(pd_state), 8'h03);
    wait_cyc(3);
    check("dn_sw_c17", 8'(sw_en), 8'h00);
    check("dn_state_c17", 8'(pd_state), 8'h04);

    // OFF: sleep ack follows request, then power-up ramp
    sleep_req = 1'b0;
    wait_cyc(1);
    check("off_ack_follow", 8'(sleep_ack), 8'h00);
    pwr_req = 1'b1;
    wait_cyc(1);
    check("up_state", 8'(pd_state), 8'h05);
    wait_cyc(3);
    check("up_sw_1", 8'(sw_en), 8'h01);
    wait_cyc(3);
    check("up_sw_2", 8'(sw_en), 8'h03);
    wait_cyc(3);
    check("up_sw_3", 8'(sw_en), 8'h07);
    wait_cyc(3);
    check("up_sw_4", 8'(sw_en), 8'h0f);
    check("up_ack_early", 8'(pwr_ack), 8'h00);
    wait_cyc(2);
    check("up_ack", 8'(pwr_ack), 8'h01);
    check("up_state6", 8'(pd_state), 8'h06);
    ctrl_on();
    wait_cyc(1);
    check("up_ack_hold", 8'(pwr_ack), 8'h01);
    pwr_req = 1'b0;
    wait_cyc(1);
    check("up_release_state", 8'(pd_state), 8'h00);
    check("up_release_ack", 8'(pwr_ack), 8'h00);

    // Power-on request arriving mid down-ramp
    sleep_req = 1'b1;
    wait_cyc(2);
    ctrl_off();
    wait_cyc(1);
    check("mid_sw_off", 8'(pd_state), 8'h03);
    wait_cyc(5);
    pwr_req = 1'b1; sleep_req = 1'b0;
    wait_cyc(7);
    check("mid_sw_zero", 8'(sw_en), 8'h00);
    check("mid_one_off", 8'(pd_state), 8'h04);
    wait_cyc(1);
    check("mid_sw_on", 8'(pd_state), 8'h05);
    wait_cyc(14);
    check("mid_pwr_ack", 8'(pwr_ack), 8'h01);
    ctrl_on();
    wait_cyc(1);
    pwr_req = 1'b0;
    wait_cyc(1);
    check("mid_back_on", 8'(pd_state), 8'h00);

    // Ordering violation while OFF
    sleep_req = 1'b1;
    wait_cyc(2);
    ctrl_off();
    wait_cyc(13);
    check("err_in_off", 8'(pd_state), 8'h04);
    check("err_pre", 8'(seq_err), 8'h00);
    clk_en = 1'b1;
    wait_cyc(1);
    check("err_set", 8'(seq_err), 8'(CHK));
    clk_en = 1'b0;
    wait_cyc(3);
    check("err_sticky", 8'(seq_err), 8'(CHK));

    // Asynchronous reset in the middle of the up-ramp
    sleep_req = 1'b0; pwr_req = 1'b1;
    wait_cyc(5);
    check("rr_sw_mid", 8'(sw_en), 8'h01);
    #2 rst = 1'b1;
    #1;
    check("rr_state", 8'(pd_state), 8'h00);
    check("rr_sw_en", 8'(sw_en), 8'h0f);
    check("rr_pwr_ack", 8'(pwr_ack), 8'h00);
    check("rr_seq_err", 8'(seq_err), 8'h00);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(3);
    check("rr_on_ignores_req", 8'(pd_state), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
